// File: rtl/rr_arbiter.sv
// Registered 2^N-way arbiter: fixed or round-robin priority, grant held
// until ack, optional forced release after TIMEOUT busy cycles.
module rr_arbiter #(
    parameter int N           = 3,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    input  logic              ack,
    output logic [2**N-1:0]   grant,
    output logic [N-1:0]      grant_idx,
    output logic              valid,
    output logic              timeout
);

    localparam int C  = 2**N;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [C-1:0]    r_grant;
    logic [C-1:0]    w_grant_nx;
    logic [N-1:0]    r_idx;
    logic [N-1:0]    w_idx_nx;
    logic [N-1:0]    r_ptr;
    logic [N-1:0]    w_ptr_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [N-1:0]    w_fix_win;
    logic [N-1:0]    w_rr_win;
    logic [N-1:0]    w_win;
    logic [N-1:0]    w_j;
    logic            w_rr_hit;
    logic            w_expire;

    // Later (higher) set bits overwrite earlier ones.
    always_comb begin
        w_fix_win = '0;
        for (int i = 0; i < C; i++) begin
            if (req[i]) begin
                w_fix_win = N'(i);
            end
        end
    end

    // Ascending search from ptr+1; N-bit addition wraps at C.
    always_comb begin
        w_rr_win = '0;
        w_rr_hit = 1'b0;
        w_j      = '0;
        for (int k = 1; k <= C; k++) begin
            w_j = r_ptr + N'(k);
            if (!w_rr_hit && req[w_j]) begin
                w_rr_win = w_j;
                w_rr_hit = 1'b1;
            end
        end
    end

    assign w_win = (ROUND_ROBIN != 0) ? w_rr_win : w_fix_win;

    generate
        if (TIMEOUT > 0) begin : g_to
            assign w_expire = (r_state == BUSY) && !ack &&
                              (r_cnt == CW'(TIMEOUT));
        end else begin : g_no_to
            assign w_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nx = BUSY;
                    w_grant_nx = C'(1) << w_win;
                    w_idx_nx   = w_win;
                    w_cnt_nx   = CW'(1);
                end
            end
            BUSY: begin
                if (ack || w_expire) begin
                    w_state_nx = IDLE;
                    w_grant_nx = '0;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    if (ROUND_ROBIN != 0) begin
                        w_ptr_nx = r_idx;
                    end
                end else if (TIMEOUT > 0) begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_idx   <= w_idx_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign valid     = (r_state == BUSY);
    assign timeout   = w_expire;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench: fixed-priority instance and round-robin instance with
// TIMEOUT=4, sharing clock and reset.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] fx_req;
    logic       fx_ack;
    logic [7:0] fx_grant;
    logic [2:0] fx_idx;
    logic       fx_valid;
    logic       fx_to;
    logic [7:0] rr_req;
    logic       rr_ack;
    logic [7:0] rr_grant;
    logic [2:0] rr_idx;
    logic       rr_valid;
    logic       rr_to;

    int n_cmp;
    int n_bad;

    rr_arbiter #(.N(3), .ROUND_ROBIN(0), .TIMEOUT(0)) u_fix (
        .clk       (clk),
        .rst       (rst),
        .req       (fx_req),
        .ack       (fx_ack),
        .grant     (fx_grant),
        .grant_idx (fx_idx),
        .valid     (fx_valid),
        .timeout   (fx_to)
    );

    rr_arbiter #(.N(3), .ROUND_ROBIN(1), .TIMEOUT(4)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (rr_req),
        .ack       (rr_ack),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .valid     (rr_valid),
        .timeout   (rr_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        fx_req = 8'b0010_1111;
        fx_ack = 1'b0;
        rr_req = 8'hFF;
        rr_ack = 1'b0;

        // reset held across two edges with requests pending
        repeat (2) tick();
        check("rst_rr_grant", 32'(rr_grant), 32'h00);
        check("rst_rr_valid", 32'(rr_valid), 32'h0);
        check("rst_rr_to", 32'(rr_to), 32'h0);
        check("rst_fx_grant", 32'(fx_grant), 32'h00);
        check("rst_fx_valid", 32'(fx_valid), 32'h0);
        rst = 1'b1;

        tick();
        check("rr_first_grant", 32'(rr_grant), 32'h01);
        check("fx_idx5", 32'(fx_idx), 32'd5);
        check("fx_grant5", 32'(fx_grant), 32'h20);
        check("fx_valid", 32'(fx_valid), 32'h1);
        fx_ack = 1'b1;

        // fairness: 0..7,0 with one idle cycle between grants
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rr_seq%0d_idx", i), 32'(rr_idx), 32'(i % 8));
            check($sformatf("rr_seq%0d_vld", i), 32'(rr_valid), 32'h1);
            rr_ack = 1'b1;
            tick();
            rr_ack = 1'b0;
            check($sformatf("rr_seq%0d_gap", i), 32'(rr_valid), 32'h0);
            if (i == 0) begin
                check("fx_ack_idle", 32'(fx_valid), 32'h0);
                fx_ack = 1'b0;
                fx_req = 8'b1010_1010;
            end
            if (i == 8) begin
                rr_req = 8'b0000_1000;
            end
            tick();
            if (i == 0) begin
                check("fx_idx7", 32'(fx_idx), 32'd7);
                fx_req = 8'h00;
            end
        end

        // ptr=0, only 3 requesting
        check("rr_get3", 32'(rr_idx), 32'd3);
        rr_ack = 1'b1;
        tick();
        rr_ack = 1'b0;
        rr_req = 8'b1000_1000;
        tick();
        check("rr_skip7", 32'(rr_idx), 32'd7);
        rr_ack = 1'b1;
        tick();
        rr_ack = 1'b0;
        tick();
        check("rr_wrap3", 32'(rr_idx), 32'd3);
        check("fx_hold", 32'(fx_grant), 32'h80);
        rr_ack = 1'b1;
        tick();
        rr_ack = 1'b0;

        // ptr=3; only 2 requests -> grant 2, then it is dropped
        rr_req = 8'h04;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("to_hold_c%0d", c), 32'(rr_grant), 32'h04);
            check($sformatf("to_pulse_c%0d", c), 32'(rr_to),
                  (c == 4) ? 32'h1 : 32'h0);
            rr_req = (c == 4) ? 8'h0C : 8'h00;
            if (c < 4) tick();
        end
        tick();
        check("to_c5_grant", 32'(rr_grant), 32'h00);
        check("to_c5_valid", 32'(rr_valid), 32'h0);
        check("to_c5_pulse", 32'(rr_to), 32'h0);
        tick();
        check("to_next3", 32'(rr_idx), 32'd3);

        // busy on 3: ack in cycle 4 beats the timeout
        repeat (3) tick();
        check("ack4_busy", 32'(rr_grant), 32'h08);
        rr_ack = 1'b1;
        #1;
        check("ack4_no_pulse", 32'(rr_to), 32'h0);
        tick();
        rr_ack = 1'b0;
        check("ack4_released", 32'(rr_valid), 32'h0);
        check("ack4_released_to", 32'(rr_to), 32'h0);

        // busy on 6, then asynchronous reset mid-cycle
        rr_req = 8'h40;
        tick();
        check("mid_busy6", 32'(rr_idx), 32'd6);
        #2;
        rst = 1'b0;
        #1;
        check("async_grant", 32'(rr_grant), 32'h00);
        check("async_valid", 32'(rr_valid), 32'h0);
        check("async_idx", 32'(rr_idx), 32'd0);
        check("async_fx", 32'(fx_grant), 32'h00);
        rr_req = 8'h41;
        rst    = 1'b1;
        tick();
        check("post_rst_idx", 32'(rr_idx), 32'd0);
        check("post_rst_grant", 32'(rr_grant), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised registered arbiter and successor to the combinational priority encoder. It grants one of 2^N requesters and holds the grant until the consumer acknowledges it. Two modes: fixed priority, where the highest index wins as in the encoder, and round-robin with a rotating pointer. An optional hold timeout releases a stalled grant. It sits in front of shared resources, such as the memory port shared by instruction and data caches or multi-way cache refill.

## Interface
- N, default 3: index width; channel count C = 2^N.
- ROUND_ROBIN, default 1: 1 = rotating priority; 0 = fixed priority (highest index wins).
- TIMEOUT, default 0: maximum BUSY cycles without ack before forced release. 0 disables the timeout.

Reset is asynchronous and active-low.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  C  request vector, one bit per channel; level-sensitive.
- ack  in  1  consumer done with the current grant; sampled only in BUSY.
- grant  out  C  one-hot registered grant; all zero when not BUSY.
- grant_idx  out  N  binary index of the granted channel; 0 when not BUSY.
- valid  out  1  high exactly while BUSY (grant != 0).
- timeout  out  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine states: IDLE, BUSY.
- IDLE:
  - If req != 0, select a winner, register grant/grant_idx/valid=1 and go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
- Winner selection in fixed mode: highest set bit of req. Example: req = 8'b00101111 gives index 5.
- Winner selection in round-robin mode:
  - Search ascending from (ptr+1) mod C, wrapping; the first set bit wins.
  - ptr is internal, N bits, and holds the last index that was acked or timed out.
- BUSY:
  - grant is held stable regardless of req changes; a dropped req does not release the grant.
  - On ack=1: go to IDLE, clear outputs, and set ptr = grant_idx (ptr update in round-robin mode only).
  - Timeout counter (TIMEOUT > 0 only):
    - Counts BUSY cycles, starting at 1 in the first BUSY cycle.
    - If the counter equals TIMEOUT and ack=0: pulse timeout for that cycle, go to IDLE next cycle, clear outputs, and set ptr = grant_idx.
  - Simultaneous ack and timeout condition: ack wins and no timeout pulse is issued.
  - Counter width is $clog2(TIMEOUT+1); it clears on leaving BUSY.
- ack while in IDLE is ignored.
- req bits outside the granted channel never affect BUSY.
- Wrap-around: when ptr = C-1, the search starts at index 0.

## Timing
- Reset values (immediate on rst low, independent of clk):
  - grant = 0, grant_idx = 0, valid = 0, timeout = 0.
  - state = IDLE, ptr = C-1 (so the first round-robin search starts at 0), timeout counter = 0.
- Latency: req seen in IDLE at edge t gives grant/valid high after edge t (visible in cycle t+1).
- Release: ack=1 sampled at edge k gives outputs zero after edge k.
- Minimum spacing between consecutive grants is one IDLE cycle (a bubble). With continuous requests and an immediate ack, the grant pattern is 1 cycle on, 1 cycle off.
- timeout is combinational from state and counter, high in the last BUSY cycle only.
- Reset asserted mid-BUSY: outputs clear asynchronously and arbitration restarts from ptr = C-1 after rst is released.
- Deassertion of rst is synchronised externally; the first arbitration occurs at the first edge with rst high.

## Test plan
- Reset check:
  - Stimulus: rst low with req = 8'hFF (N=3).
  - Required: grant = 0, valid = 0, timeout = 0.
  - After rst high, round-robin grants index 0 (grant = 8'h01) one cycle after the first edge.
- Fixed mode:
  - Stimulus: ROUND_ROBIN=0, req = 8'b00101111. Required: grant_idx = 5, grant = 8'b00100000, valid = 1.
  - Stimulus: after ack, req = 8'b10101010. Required: grant_idx = 7.
- Round-robin fairness:
  - Stimulus: req held at 8'hFF, ack pulsed one cycle after each grant.
  - Required: grant_idx sequence 0,1,2,3,4,5,6,7,0, with exactly one idle cycle between grants.
- Round-robin skip and wrap:
  - Stimulus: after an acked grant of index 3, req = 8'b10001000. Required: next grant is 7.
  - Required: after ack, the following grant is 3 (wrap through 0..2, which are not requesting).
- Grant hold and timeout (TIMEOUT=4):
  - Stimulus: grant index 2, drop req[2], no ack.
  - Required: grant stays 8'h04 for 4 cycles, timeout pulses in cycle 4, outputs are zero in cycle 5, and the next round-robin search starts at 3.
  - Stimulus: repeat with ack in cycle 4. Required: no timeout pulse.
- Reset mid-operation:
  - Stimulus: rst pulled low while BUSY on index 6.
  - Required: outputs zero without waiting for a clock edge.
  - After release with req = 8'h41, grant_idx = 0, confirming ptr was reset.
